// File: rtl/alu_pkg.sv
// alu_pkg: shared opcodes, flag bit positions and FSM states for alu_seq.
package alu_pkg;
    localparam logic [3:0] OP_ADC = 4'd0;
    localparam logic [3:0] OP_SBC = 4'd1;
    localparam logic [3:0] OP_OR  = 4'd2;
    localparam logic [3:0] OP_XOR = 4'd3;
    localparam logic [3:0] OP_AND = 4'd4;
    localparam logic [3:0] OP_LSR = 4'd5;
    localparam logic [3:0] OP_ASL = 4'd6;
    localparam logic [3:0] OP_ROL = 4'd7;
    localparam logic [3:0] OP_ROR = 4'd8;
    localparam logic [3:0] OP_CMP = 4'd9;
    localparam int FN = 3;
    localparam int FV = 2;
    localparam int FZ = 1;
    localparam int FC = 0;
    typedef enum logic [1:0] {IDLE, EXEC, ADJ, DONE} state_t;
endpackage

// File: rtl/alu_seq_if.sv
// alu_seq_if: operand and result valid/ready channels of alu_seq.
interface alu_seq_if #(
    parameter int DATA_WIDTH = 8,
    parameter int OP_WIDTH = 4
);
    logic op_valid, op_ready, op_carry, op_dec;
    logic [OP_WIDTH-1:0] op_code;
    logic [DATA_WIDTH-1:0] op_a, op_b, res_y;
    logic res_valid, res_ready;
    logic [3:0] res_flags, res_mask;
    modport master (
        output op_valid, op_code, op_a, op_b, op_carry, op_dec, res_ready,
        input op_ready, res_valid, res_y, res_flags, res_mask
    );
    modport slave (
        input op_valid, op_code, op_a, op_b, op_carry, op_dec, res_ready,
        output op_ready, res_valid, res_y, res_flags, res_mask
    );
endinterface

// File: rtl/alu_bcd_digit.sv
// alu_bcd_digit: one decimal digit add (carry) or subtract (borrow); non-BCD digits wrap mod 16.
module alu_bcd_digit (
    input logic [3:0] a,
    input logic [3:0] b,
    input logic cin,
    input logic sub,
    output logic [3:0] d,
    output logic cout
);
    logic [4:0] s, t;
    assign s = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
    assign t = {1'b0, a} - {1'b0, b} - {4'b0000, cin};
    assign cout = sub ? t[4] : s > 5'd9;
    assign d = sub ? t[3:0] + (cout ? 4'd10 : 4'd0) : s[3:0] - (cout ? 4'd10 : 4'd0);
endmodule

// File: rtl/alu_seq.sv
// alu_seq: registered 6502-style ALU with valid/ready handshake and per-op N V Z C flag mask.
// Decimal ADC/SBC (one BCD digit per ADJ cycle) is built only when ALU_BCD_EN is defined.
module alu_seq
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int OP_WIDTH = 4
) (
    input logic clk,
    input logic rst_n,
    alu_seq_if.slave bus
);
    localparam int MSB = DATA_WIDTH - 1;
    state_t state, state_nx;
    logic [3:0] op, bm, flags, mask;
    logic [MSB:0] a, b, bb, by, y;
    logic [DATA_WIDTH:0] sum;
    logic cin, bc, bv, is_dec, adj_done;
    assign bus.op_ready = state == IDLE;
    assign bus.res_valid = state == DONE;
    assign bus.res_y = y;
    assign bus.res_flags = flags;
    assign bus.res_mask = mask;
    assign bb = op == OP_ADC ? b : ~b;
    assign sum = {1'b0, a} + {1'b0, bb} + {{DATA_WIDTH{1'b0}}, op == OP_CMP ? 1'b1 : cin};
    always_comb begin
        by = a;
        bc = 1'b0;
        bm = 4'b0000;
        case (op)
            OP_ADC, OP_SBC, OP_CMP: begin by = sum[MSB:0]; bc = sum[DATA_WIDTH]; bm = op == OP_CMP ? 4'b1011 : 4'b1111; end
            OP_OR:  begin by = a | b; bm = 4'b1010; end
            OP_XOR: begin by = a ^ b; bm = 4'b1010; end
            OP_AND: begin by = a & b; bm = 4'b1010; end
            OP_LSR: begin {by, bc} = {1'b0, a}; bm = 4'b1011; end
            OP_ASL: begin {bc, by} = {a, 1'b0}; bm = 4'b1011; end
            OP_ROL: begin {bc, by} = {a, cin}; bm = 4'b1011; end
            OP_ROR: begin {by, bc} = {cin, a}; bm = 4'b1011; end
            default: ;
        endcase
        bv = (op == OP_ADC || op == OP_SBC) && a[MSB] == bb[MSB] && by[MSB] != a[MSB];
    end
`ifdef ALU_BCD_EN
    localparam int ND = DATA_WIDTH / 4;
    localparam int CW = $clog2(ND);
    logic dec, dc, dco;
    logic [3:0] dd;
    logic [CW-1:0] cnt;
    assign is_dec = dec && (op == OP_ADC || op == OP_SBC);
    assign adj_done = cnt == CW'(ND - 1);
    // a and b shift right each digit so the single digit unit always sees bits [3:0]
    alu_bcd_digit u_digit (.a(a[3:0]), .b(b[3:0]), .cin(dc), .sub(op == OP_SBC), .d(dd), .cout(dco));
`else
    assign is_dec = 1'b0;
    assign adj_done = 1'b1;
`endif
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: state_nx = bus.op_valid ? EXEC : IDLE;
            EXEC: state_nx = is_dec ? ADJ : DONE;
            ADJ:  state_nx = adj_done ? DONE : ADJ;
            DONE: state_nx = bus.res_ready ? IDLE : DONE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (bus.op_valid && bus.op_ready) begin
            op <= bus.op_code > OP_WIDTH'(OP_CMP) ? 4'hF : bus.op_code[3:0];
            a <= bus.op_a;
            b <= bus.op_b;
            cin <= bus.op_carry;
`ifdef ALU_BCD_EN
            dec <= bus.op_dec;
`endif
        end
`ifdef ALU_BCD_EN
        if (state == EXEC) begin
            cnt <= '0;
            dc <= op == OP_SBC ? ~cin : cin;
        end
        if (state == ADJ) begin
            a <= a >> 4;
            b <= b >> 4;
            cnt <= cnt + 1'b1;
            dc <= dco;
        end
`endif
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            y <= '0;
            flags <= '0;
            mask <= '0;
        end else begin
            state <= state_nx;
            if (state == EXEC) begin
                y <= by;
                flags <= {by[MSB], bv, ~|by, bc} & bm;
                mask <= bm;
            end
`ifdef ALU_BCD_EN
            // digits enter at the top and walk down; V keeps its binary value from EXEC
            if (state == ADJ) begin
                y <= {dd, y[MSB:4]};
                if (adj_done) flags <= {dd[3], flags[FV], ~|{dd, y[MSB:4]}, op == OP_SBC ? ~dco : dco};
            end
`endif
        end
    end
endmodule
